// File: rtl/div_seq.sv
/*--------------------------------------------------------------------------
 * Module      : div_seq
 * Description : 32-iteration restoring divide sequencer, {rem, quo} result.
 *               Optional DIV_ZERO_FAST_EN short-circuits divide-by-zero.
 * Revision    : 1.0 - initial release
 *------------------------------------------------------------------------*/
`default_nettype none

module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

`ifdef DIV_ZERO_FAST_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ZERO = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd2, DONE = 2'd3} state_t;
`endif

  state_t      state, state_n;
  logic [5:0]  cnt, cnt_n;
  logic [64:0] sr, sr_n;
  logic [31:0] dvs, dvs_n;
  logic        neg_q, neg_q_n;
  logic        neg_r, neg_r_n;
  logic [63:0] result_n;
  logic        ready_n;

  logic [32:0] diff;
  logic [31:0] op1_mag;
  logic [31:0] op2_mag;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  // Magnitudes used on RUN entry; unsigned operands pass straight through.
  assign op1_mag = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign op2_mag = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  assign diff  = {1'b0, sr[63:32]} - {1'b0, dvs};
  assign q_fix = neg_q ? (~sr[31:0] + 32'd1)  : sr[31:0];
  assign r_fix = neg_r ? (~sr[64:33] + 32'd1) : sr[64:33];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 6'd0;
      sr       <= 65'd0;
      dvs      <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= 64'h0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sr       <= sr_n;
      dvs      <= dvs_n;
      neg_q    <= neg_q_n;
      neg_r    <= neg_r_n;
      result_o <= result_n;
      ready_o  <= ready_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sr_n     = sr;
    dvs_n    = dvs;
    neg_q_n  = neg_q;
    neg_r_n  = neg_r;
    result_n = result_o;
    ready_n  = ready_o;

    if (annul_i) begin
      // Flush wins over every transition and drops any partial work.
      state_n  = IDLE;
      cnt_n    = 6'd0;
      sr_n     = 65'd0;
      dvs_n    = 32'd0;
      neg_q_n  = 1'b0;
      neg_r_n  = 1'b0;
      result_n = 64'h0;
      ready_n  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
`ifdef DIV_ZERO_FAST_EN
            if (opdata2_i == 32'd0) begin
              state_n = ZERO;
            end else
`endif
            begin
              state_n = RUN;
              sr_n    = {32'd0, op1_mag, 1'b0};
              dvs_n   = op2_mag;
              cnt_n   = 6'd0;
              neg_q_n = signed_div_i && (opdata1_i[31] != opdata2_i[31]);
              neg_r_n = signed_div_i && opdata1_i[31];
            end
          end
        end
`ifdef DIV_ZERO_FAST_EN
        ZERO: begin
          state_n  = DONE;
          result_n = 64'h0;
          ready_n  = 1'b1;
        end
`endif
        RUN: begin
          if (cnt != 6'd32) begin
            if (diff[32]) begin
              sr_n = {sr[63:0], 1'b0};
            end else begin
              sr_n = {diff[31:0], sr[31:0], 1'b1};
            end
            cnt_n = cnt + 6'd1;
          end else begin
            result_n = {r_fix, q_fix};
            ready_n  = 1'b1;
            state_n  = DONE;
          end
        end
        DONE: begin
          if (!start_i) begin
            state_n  = IDLE;
            result_n = 64'h0;
            ready_n  = 1'b0;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_seq.sv
/*--------------------------------------------------------------------------
 * Module      : tb_div_seq
 * Description : Self-checking bench for div_seq (honours DIV_ZERO_FAST_EN).
 * Revision    : 1.0 - initial release
 *------------------------------------------------------------------------*/
`default_nettype none

module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div = 1'b0;
  logic [31:0] op1 = 32'd0;
  logic [31:0] op2 = 32'd0;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 34;
`endif

  div_seq dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  // Arithmetic reference: truncating division on magnitudes, then sign fix.
  function automatic logic [63:0] ref_div(bit sgn, logic [31:0] a, logic [31:0] b);
    logic [63:0] ma, mb, q, r;
    logic [31:0] qo, ro;
    bit na, nb;
    na = sgn && a[31];
    nb = sgn && b[31];
    ma = na ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
    mb = nb ? (64'h1_0000_0000 - {32'd0, b}) : {32'd0, b};
    if (mb == 64'd0) begin
      q = 64'h0000_0000_FFFF_FFFF;
      r = ma;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    qo = q[31:0];
    ro = r[31:0];
    if (na != nb) qo = -qo;
    if (na) ro = -ro;
`ifdef DIV_ZERO_FAST_EN
    if (b == 32'd0) return 64'h0;
`endif
    return {ro, qo};
  endfunction

  // Transaction-level model: busy countdown then a held ready/result.
  bit          m_busy = 1'b0;
  bit          m_ready = 1'b0;
  int          m_cnt = 0;
  logic [63:0] m_res = 64'h0;

  always @(posedge clk) begin
    if (rst || annul) begin
      m_busy  = 1'b0;
      m_ready = 1'b0;
    end else if (m_ready) begin
      if (!start) m_ready = 1'b0;
    end else if (m_busy) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_busy  = 1'b0;
        m_ready = 1'b1;
      end
    end else if (start) begin
      m_busy = 1'b1;
      m_res  = ref_div(signed_div, op1, op2);
`ifdef DIV_ZERO_FAST_EN
      m_cnt  = (op2 == 32'd0) ? 1 : 33;
`else
      m_cnt  = 33;
`endif
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (ready_o !== m_ready || result_o !== (m_ready ? m_res : 64'h0)) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t got ready=%b result=%h want ready=%b result=%h",
                 $time, ready_o, result_o, m_ready, m_ready ? m_res : 64'h0);
      end
    end
  end

  task automatic start_op(bit sgn, logic [31:0] a, logic [31:0] b);
    @(negedge clk);
    signed_div = sgn;
    op1        = a;
    op2        = b;
    start      = 1'b1;
  endtask

  // Counts cycles from the next (start-sampling) edge until ready_o.
  task automatic wait_ready(string name, logic [63:0] exp, int lat);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ready_o && n < 100);
    checks++;
    if (!ready_o || n != lat || result_o !== exp) begin
      errors++;
      $display("FAIL %s got ready=%b cycle=%0d result=%h want cycle=%0d result=%h",
               name, ready_o, n, result_o, lat, exp);
    end
  endtask

  task automatic finish_op(string name);
    repeat (3) @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      errors++;
      $display("FAIL %s_drop got ready=%b result=%h want ready=0 result=0",
               name, ready_o, result_o);
    end
  endtask

  task automatic run_op(string name, bit sgn, logic [31:0] a, logic [31:0] b,
                        logic [63:0] exp, int lat);
    start_op(sgn, a, b);
    wait_ready(name, exp, lat);
    finish_op(name);
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      errors++;
      $display("FAIL reset got ready=%b result=%h want ready=0 result=0", ready_o, result_o);
    end
    rst = 1'b0;

    run_op("u100_7",   1'b0, 32'd100,        32'd7,          {32'd2, 32'd14}, 34);
    run_op("s-7_2",    1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD}, 34);
    run_op("s7_-2",    1'b1, 32'd7,          32'hFFFFFFFE,   {32'h1, 32'hFFFFFFFD}, 34);
    run_op("s_ovf",    1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'h0, 32'h80000000}, 34);
    run_op("uFFFF_10", 1'b0, 32'hFFFFFFFF,   32'h10,         {32'hF, 32'h0FFFFFFF}, 34);
`ifdef DIV_ZERO_FAST_EN
    run_op("u5_0",     1'b0, 32'd5,          32'd0,          64'h0, ZLAT);
    run_op("s-5_0",    1'b1, 32'hFFFFFFFB,   32'd0,          64'h0, ZLAT);
`else
    run_op("u5_0",     1'b0, 32'd5,          32'd0,          {32'd5, 32'hFFFFFFFF}, ZLAT);
    run_op("s-5_0",    1'b1, 32'hFFFFFFFB,   32'd0,          {32'hFFFFFFFB, 32'h00000001}, ZLAT);
`endif

    // Flush mid-RUN, then a new operation straight after.
    start_op(1'b0, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    annul = 1'b1;
    op1   = 32'd9;
    op2   = 32'd3;
    @(negedge clk);
    annul = 1'b0;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      errors++;
      $display("FAIL annul got ready=%b result=%h want ready=0 result=0", ready_o, result_o);
    end
    wait_ready("annul_9_3", {32'd0, 32'd3}, 34);
    finish_op("annul_9_3");

    // Reset mid-RUN with start held.
    start_op(1'b0, 32'd100, 32'd7);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      errors++;
      $display("FAIL midrst got ready=%b result=%h want ready=0 result=0", ready_o, result_o);
    end
    wait_ready("after_rst", {32'd2, 32'd14}, 34);
    finish_op("after_rst");

    // Dropping start during RUN must not abort the operation.
    start_op(1'b0, 32'd50, 32'd6);
    repeat (5) @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      errors++;
      $display("FAIL start_drop_run got ready=%b result=%h want ready=0 result=0",
               ready_o, result_o);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
